// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // One restoring step per quotient bit.
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  // Quotient reported for a zero divisor.
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// Single restoring radix-2 divide iteration (combinational).
// Latency: 0 cycles; the caller registers the result once per cycle.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   rq_i      {remainder, quotient} pair before the step
//   divisor_i divisor (magnitude)
//   rq_o      {remainder, quotient} pair after the step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] rq_o
);

  logic [WIDTH:0] sh_rem;
  logic [WIDTH:0] diff;

  always_comb begin
    // Shift the pair left by one; the remainder needs one extra bit because
    // the bit leaving the top of the remainder still takes part in the compare.
    sh_rem = rq_i[2*WIDTH-1:WIDTH-1];
    diff   = sh_rem - {1'b0, divisor_i};
    // A set top bit in diff means the trial subtraction borrowed: restore.
    if (diff[WIDTH]) begin
      rq_o = {sh_rem[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b0};
    end else begin
      rq_o = {diff[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with an iterative DIV/DIVU engine for the MIPS execute stage.
// Latency: divide 33 cycles start-to-result; mul/MTHI/MTLO writes visible next cycle.
// Backpressure: busy stalls the pipeline; start while busy is ignored; any HI/LO write aborts a divide.
//
// Optional feature macro: HILO_SIGNED_DIV_EN (signed DIV honoured when defined,
// otherwise every divide is unsigned and is_signed is ignored).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, is_signed      divide request and DIV/DIVU select (sampled when idle)
//   dividend, divisor     rs / rt operands
//   mul_we, mul_hi/mul_lo multiply result capture (wins over MTHI/MTLO)
//   wr_hi, wr_lo, wr_data MTHI / MTLO
//   busy, done            divide in progress / one-cycle result pulse
//   hi, lo                registered HI / LO
module hilo_div_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mul_we,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] DIV0_Q   = WIDTH'({((WIDTH + 31) / 32){DIV0_QUOT}});
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] rq_q, rq_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   dvnd_q, dvnd_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] step_rq;
  logic               wr_any;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   quot, rem;

`ifdef HILO_SIGNED_DIV_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
  logic a_neg, b_neg;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
`endif

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rq_i      (rq_q),
    .divisor_i (dvsr_q),
    .rq_o      (step_rq)
  );

  assign wr_any = mul_we | wr_hi | wr_lo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rq_d    = rq_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    a_mag   = dividend;
    b_mag   = divisor;
    quot    = rq_q[WIDTH-1:0];
    rem     = rq_q[2*WIDTH-1:WIDTH];
`ifdef HILO_SIGNED_DIV_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    a_neg      = is_signed & dividend[WIDTH-1];
    b_neg      = is_signed & divisor[WIDTH-1];
    if (a_neg) a_mag = ~dividend + WIDTH'(1);
    if (b_neg) b_mag = ~divisor + WIDTH'(1);
    // 0x80000000 / -1 needs no special case: its magnitude divide yields
    // 0x80000000, and negating that in WIDTH bits leaves it unchanged.
    if (neg_quot_q) quot = ~rq_q[WIDTH-1:0] + WIDTH'(1);
    if (neg_rem_q)  rem  = ~rq_q[2*WIDTH-1:WIDTH] + WIDTH'(1);
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          rq_d    = {{WIDTH{1'b0}}, a_mag};
          dvsr_d  = b_mag;
          dvnd_d  = dividend;
          div0_d  = (divisor == '0);
`ifdef HILO_SIGNED_DIV_EN
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
`endif
        end
      end
      RUN: begin
        if (wr_any) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rq_d = step_rq;
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        // A write landing on the writeback cycle still wins and suppresses done.
        if (!wr_any) begin
          done_d = 1'b1;
          if (div0_q) begin
            lo_d = DIV0_Q;
            hi_d = dvnd_q;
          end else begin
            lo_d = quot;
            hi_d = rem;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Explicit HI/LO writes take effect in every state; the FSM above
    // already aborts a divide that is in flight.
    if (mul_we) begin
      hi_d = mul_hi;
      lo_d = mul_lo;
    end else begin
      if (wr_hi) hi_d = wr_data;
      if (wr_lo) lo_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rq_q    <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef HILO_SIGNED_DIV_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rq_q    <= rq_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef HILO_SIGNED_DIV_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: divide vector table plus hand-written
// sequences for HI/LO writes, aborts, ignored start, mid-divide reset and
// back-to-back divides.
module tb_hilo_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        mul_we;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .mul_we    (mul_we),
    .mul_hi    (mul_hi),
    .mul_lo    (mul_lo),
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a divide request for one edge (E0); returns #1 after E0.
  // With now=1 the request is driven immediately instead of at the next negedge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sg, input bit now);
    if (!now) @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = sg;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; lat=0 means the bound expired.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  // Watches a bounded window and reports how many done pulses appeared.
  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1]  = '{32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234};
    vecs[2]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    vecs[3]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0};
    vecs[4]  = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5};
    vecs[5]  = '{32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA,  32'd2};
    vecs[6]  = '{32'hDEAD_BEEF,  32'h10,         1'b0, 32'h0DEA_DBEE,  32'hF};
    // Divide by zero reports the raw dividend in HI in either mode.
    vecs[7]  = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB};
`ifdef HILO_SIGNED_DIV_EN
    vecs[8]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[9]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    vecs[10] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
`else
    // Same operands, is_signed ignored: plain unsigned results.
    vecs[8]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1};
    vecs[9]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000};
    vecs[10] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'd0,          32'd7};
`endif

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    mul_we = 1'b0; mul_hi = '0; mul_lo = '0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst_n = 1'b1;

    // Divide table
    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sg, 1'b0);
      check($sformatf("v%0d_busy_e0", i), {31'd0, busy}, 32'd1);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), lat, 32'd33);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // mul_we beats MTHI in the same cycle; no same-cycle bypass
    @(negedge clk);
    mul_we = 1'b1; mul_hi = 32'hA; mul_lo = 32'hB;
    wr_hi = 1'b1; wr_data = 32'h5;
    #1;
    check("nobypass_hi", hi, vecs[NV-1].exp_hi);
    check("nobypass_lo", lo, vecs[NV-1].exp_lo);
    @(posedge clk);
    #1;
    mul_we = 1'b0; wr_hi = 1'b0;
    check("mul_hi", hi, 32'hA);
    check("mul_lo", lo, 32'hB);

    // MTHI and MTLO together
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h77;
    @(posedge clk);
    #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mt_both_hi", hi, 32'h77);
    check("mt_both_lo", lo, 32'h77);

    // MTLO during a divide aborts it
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    wr_lo = 1'b1; wr_data = 32'h55;
    @(posedge clk);
    #1;
    wr_lo = 1'b0;
    check("abort_lo", lo, 32'h55);
    check("abort_hi", hi, 32'h77);
    check("abort_busy", {31'd0, busy}, 32'd0);
    count_done(40, seen);
    check("abort_no_done", seen, 32'd0);

    // start while busy is ignored
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("ignore_latency", (lat == 0) ? 0 : lat + 5, 32'd33);
    check("ignore_lo", lo, 32'd14);
    check("ignore_hi", hi, 32'd2);

    // Back-to-back: second start presented in the done cycle
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    wait_done(lat);
    check("b2b_first_lat", lat, 32'd33);
    check("b2b_first_lo", lo, 32'd14);
    check("b2b_first_hi", hi, 32'd2);
    launch(32'h1234, 32'h10, 1'b0, 1'b1);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("b2b_second_lat", lat, 32'd33);
    check("b2b_second_lo", lo, 32'h123);
    check("b2b_second_hi", hi, 32'h4);

    // Reset in the middle of a divide
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    count_done(40, seen);
    check("midrst_no_done", seen, 32'd0);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
